// File: rtl/lfsr_seq_checker_if.sv
// Sample stream into the LFSR sequence checker and its status outputs back out.
// The producer side (generator or bench) uses master; the checker uses slave.
interface lfsr_seq_checker_if #(
    parameter int CNT_W = 16
);
    logic             valid_in;
    logic [19:0]      q_in;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] err_count;
    logic             zero_seen;

    modport master (
        output valid_in, q_in,
        input  locked, error, err_count, zero_seen
    );

    modport slave (
        input  valid_in, q_in,
        output locked, error, err_count, zero_seen
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 20-bit LFSR stream: predicts each sample with the
// generator recurrence, locks after a run of hits and drops lock after a run of misses.
module lfsr_seq_checker #(
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    lfsr_seq_checker_if.slave  bus
);

    localparam int MAX_RUN = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int RUN_W   = $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] LOCK_R = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] LOSS_R = RUN_W'(LOSS_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [19:0]      pred;
    logic [19:0]      pred_nxt;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic [RUN_W-1:0] run_inc;
    logic             hit;
    logic             sample_zero;
    logic             miss;
    logic             error_r;
    logic [CNT_W-1:0] err_count_r;
    logic             zero_seen_r;

    function automatic logic [19:0] nxt(input logic [19:0] v);
        return {v[18:0], v[19] ^ v[2]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign run_inc     = run + RUN_W'(1);
    assign sample_zero = (bus.q_in == 20'h00000);
    // pred is never zero once loaded, but a zero sample must never count as a hit
    assign hit         = (bus.q_in == pred) && !sample_zero;

    // ---- state register ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- prediction, run counter and error bookkeeping ----
    always_ff @(posedge clock) begin
        if (reset) begin
            pred        <= '0;
            run         <= '0;
            error_r     <= 1'b0;
            err_count_r <= '0;
            zero_seen_r <= 1'b0;
        end else begin
            pred    <= pred_nxt;
            run     <= run_nxt;
            error_r <= miss;
            if (miss) begin
                err_count_r <= sat_inc(err_count_r);
            end
            if (bus.valid_in && sample_zero) begin
                zero_seen_r <= 1'b1;
            end
        end
    end

    // ---- next state ----
    always_comb begin
        state_nxt = state;
        pred_nxt  = pred;
        run_nxt   = run;
        miss      = 1'b0;
        if (bus.valid_in) begin
            case (state)
                SEARCH: begin
                    if (!sample_zero) begin
                        pred_nxt  = nxt(bus.q_in);
                        run_nxt   = '0;
                        state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        pred_nxt = nxt(pred);
                        if (run_inc == LOCK_R) begin
                            run_nxt   = '0;
                            state_nxt = LOCKED;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else if (sample_zero) begin
                        run_nxt   = '0;
                        state_nxt = SEARCH;
                    end else begin
                        pred_nxt = nxt(bus.q_in);
                        run_nxt  = '0;
                    end
                end
                LOCKED: begin
                    // flywheel: the prediction advances whether or not the sample agrees
                    pred_nxt = nxt(pred);
                    if (hit) begin
                        run_nxt = '0;
                    end else begin
                        miss = 1'b1;
                        if (run_inc == LOSS_R) begin
                            run_nxt   = '0;
                            state_nxt = SEARCH;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end
                end
                default: begin
                    run_nxt   = '0;
                    state_nxt = SEARCH;
                end
            endcase
        end
    end

    // ---- outputs ----
    always_comb begin
        bus.locked    = (state == LOCKED);
        bus.error     = error_r;
        bus.err_count = err_count_r;
        bus.zero_seen = zero_seen_r;
    end

endmodule
